// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern generator with pixel-clock
// enable divider, sync polarity control, frame-latched pattern select and pixel/line/frame strobes.
module vga_pattern_gen #(
    parameter int H_RES    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_RES    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 8,
    parameter int CHK_LOG2 = 5,
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP,
    localparam int X_W     = $clog2(H_TOTAL),
    localparam int Y_W     = $clog2(V_TOTAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_active,
    output logic [X_W-1:0]       pixel_x,
    output logic [Y_W-1:0]       pixel_y,
    output logic                 pix_valid,
    output logic                 line_start,
    output logic                 frame_start,
    output logic [COLOR_W-1:0]   rgb_r,
    output logic [COLOR_W-1:0]   rgb_g,
    output logic [COLOR_W-1:0]   rgb_b
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W = H_RES / 8 > 0 ? H_RES / 8 : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [X_W-1:0]     h_cnt;
    logic [Y_W-1:0]     v_cnt;
    logic [1:0]         mode_q;
    logic               fresh;
    logic               pix_ce, h_end, v_end, show, act, hs_on, vs_on, chk;
    logic [31:0]        hx, vy, idx;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] sum, r_n, g_n, b_n;

    assign pix_ce = en && div_cnt == DIV_LAST;
    assign h_end  = h_cnt == H_LAST;
    assign v_end  = v_cnt == V_LAST;
    assign show   = en && fresh;
    assign hx     = 32'(h_cnt);
    assign vy     = 32'(v_cnt);

    // fresh marks that the counters hold a position not yet presented on the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            mode_q  <= mode;
            fresh   <= 1'b1;
        end else if (en) begin
            div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
            fresh   <= pix_ce;
            if (pix_ce) begin
                h_cnt <= h_end ? '0 : h_cnt + 1'b1;
                if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
                if (h_end && v_end) mode_q <= mode;
            end
        end
    end

    always_comb begin
        act   = hx < H_RES && vy < V_RES;
        hs_on = hx >= H_RES + H_FP && hx < H_RES + H_FP + H_SYNC;
        vs_on = vy >= V_RES + V_FP && vy < V_RES + V_FP + V_SYNC;
        idx   = hx / BAR_W;
        bar   = idx > 32'd7 ? 3'd7 : idx[2:0];
        chk   = hx[CHK_LOG2] ^ vy[CHK_LOG2];
        sum   = COLOR_W'(hx + vy);
        // bar order white..black maps to {g,r,b} = ~idx
        r_n = mode_q == 2'd0 ? solid_rgb[3*COLOR_W-1:2*COLOR_W] :
              mode_q == 2'd1 ? hx[COLOR_W-1:0] :
              mode_q == 2'd2 ? {COLOR_W{~bar[1]}} : {COLOR_W{~chk}};
        g_n = mode_q == 2'd0 ? solid_rgb[2*COLOR_W-1:COLOR_W] :
              mode_q == 2'd1 ? vy[COLOR_W-1:0] :
              mode_q == 2'd2 ? {COLOR_W{~bar[2]}} : {COLOR_W{~chk}};
        b_n = mode_q == 2'd0 ? solid_rgb[COLOR_W-1:0] :
              mode_q == 2'd1 ? sum :
              mode_q == 2'd2 ? {COLOR_W{~bar[0]}} : {COLOR_W{~chk}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid    <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            video_active <= 1'b0;
            hsync        <= ~H_POL;
            vsync        <= ~V_POL;
            pixel_x      <= '0;
            pixel_y      <= '0;
            rgb_r        <= '0;
            rgb_g        <= '0;
            rgb_b        <= '0;
        end else begin
            pix_valid   <= show;
            line_start  <= show && hx == 0 && vy < V_RES;
            frame_start <= show && hx == 0 && vy == 0;
            if (show) begin
                video_active <= act;
                hsync        <= hs_on ? H_POL : ~H_POL;
                vsync        <= vs_on ? V_POL : ~V_POL;
                pixel_x      <= act ? h_cnt : '0;
                pixel_y      <= act ? v_cnt : '0;
                rgb_r        <= act ? r_n : '0;
                rgb_g        <= act ? g_n : '0;
                rgb_b        <= act ? b_n : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: two reduced-size instances (CLK_DIV=1 active-low syncs, CLK_DIV=4 active-high
// syncs) checked every cycle against a frame-position reference model plus fixed expected values.
module tb_vga_pattern_gen;
    localparam int HR = 64, HF = 4, HS = 8, HB = 4, HT = HR + HF + HS + HB;
    localparam int VR = 40, VF = 3, VS = 2, VB = 3, VT = VR + VF + VS + VB;
    localparam int FL = HT * VT, CL = 3;

    typedef struct packed {
        logic pv, ls, fs, act, hs, vs;
        logic [6:0] x;
        logic [5:0] y;
        logic [7:0] r, g, b;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;
    logic [1:0] mode;
    logic [23:0] solid;
    logic hs[2], vs[2], act[2], pv[2], ls[2], fs[2];
    logic [6:0] px[2];
    logic [5:0] py[2];
    logic [7:0] r[2], g[2], b[2];
    int errors = 0, checks = 0;

    vga_pattern_gen #(.H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_RES(VR), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1), .COLOR_W(8),
        .CHK_LOG2(CL)) dut_d1 (.clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
        .hsync(hs[0]), .vsync(vs[0]), .video_active(act[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .pix_valid(pv[0]), .line_start(ls[0]), .frame_start(fs[0]), .rgb_r(r[0]), .rgb_g(g[0]),
        .rgb_b(b[0]));

    vga_pattern_gen #(.H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_RES(VR), .V_FP(VF),
        .V_SYNC(VS), .V_BP(VB), .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(4), .COLOR_W(8),
        .CHK_LOG2(CL)) dut_d4 (.clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
        .hsync(hs[1]), .vsync(vs[1]), .video_active(act[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .pix_valid(pv[1]), .line_start(ls[1]), .frame_start(fs[1]), .rgb_r(r[1]), .rgb_g(g[1]),
        .rgb_b(b[1]));

    function automatic int divof(int d);
        return d == 1 ? 4 : 1;
    endfunction

    // expected outputs for linear frame position pos; hs/vs mean "sync asserted"
    function automatic pix_t ref_pix(int pos, logic [1:0] m, logic [23:0] s);
        pix_t p;
        int h, v, bi;
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        h = pos % HT;
        v = pos / HT;
        p = '0;
        p.pv = 1'b1;
        p.ls = h == 0 && v < VR;
        p.fs = pos == 0;
        p.act = h < HR && v < VR;
        p.hs = h >= HR + HF && h < HR + HF + HS;
        p.vs = v >= VR + VF && v < VR + VF + VS;
        if (p.act) begin
            p.x = 7'(h);
            p.y = 6'(v);
            bi = h / (HR / 8) > 7 ? 7 : h / (HR / 8);
            case (m)
                2'd0: {p.r, p.g, p.b} = s;
                2'd1: begin p.r = 8'(h); p.g = 8'(v); p.b = 8'(h + v); end
                2'd2: {p.r, p.g, p.b} = bars[bi];
                default: {p.r, p.g, p.b} = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 24'h0 : 24'hFFFFFF;
            endcase
        end
        return p;
    endfunction

    function automatic pix_t dut_vec(int d);
        return {pv[d], ls[d], fs[d], act[d], hs[d] == (d == 1), vs[d] == (d == 1),
                px[d], py[d], r[d], g[d], b[d]};
    endfunction

    // model: n counts enabled clocks since reset; each pixel spans divof(d) of them
    pix_t e[2];
    int n[2];
    logic [1:0] mprev[2], fmode[2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                n[d] <= 0;
                mprev[d] <= mode;
                e[d] <= '0;
            end else if (en) begin
                n[d] <= n[d] + 1;
                mprev[d] <= mode;
                if (n[d] % divof(d) == 0) begin
                    if ((n[d] / divof(d)) % FL == 0) fmode[d] <= mprev[d];
                    e[d] <= ref_pix((n[d] / divof(d)) % FL,
                                    (n[d] / divof(d)) % FL == 0 ? mprev[d] : fmode[d], solid);
                end else begin
                    e[d].pv <= 1'b0; e[d].ls <= 1'b0; e[d].fs <= 1'b0;
                end
            end else begin
                e[d].pv <= 1'b0; e[d].ls <= 1'b0; e[d].fs <= 1'b0;
            end
        end
    end

    task test_reset;
        rst = 1'b1; en = 1'b1; mode = 2'd1; solid = 24'($urandom);
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL reset_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
        end
        checks++;
        if ({hs[0], vs[0], hs[1], vs[1]} !== 4'b1100) begin errors++; $display("FAIL reset_sync got=%b exp=1100", {hs[0], vs[0], hs[1], vs[1]}); end
        checks++;
        if ({pv[0], act[0], px[0], r[0], pv[1], act[1], px[1], b[1]} !== '0) begin errors++; $display("FAIL reset_zero got nonzero outputs"); end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL first_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            checks++;
            if ({fs[d], ls[d], pv[d], act[d], px[d], py[d], r[d], g[d], b[d]} !== {4'b1111, 37'd0})
                begin errors++; $display("FAIL first_pixel dut%0d got=%b%b%b%b x=%0d y=%0d rgb=%h exp=1111 0 0 000000", d, fs[d], ls[d], pv[d], act[d], px[d], py[d], {r[d], g[d], b[d]}); end
        end
    endtask

    task test_gradient;
        repeat (50) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL gradient_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
        end
        checks++;
        if ({px[0], py[0], r[0], g[0], b[0]} !== {7'd50, 6'd0, 24'h320032}) begin errors++; $display("FAIL gradient_x50 got x=%0d y=%0d rgb=%h exp x=50 y=0 rgb=320032", px[0], py[0], {r[0], g[0], b[0]}); end
        repeat (HT) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL gradient_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
        end
        checks++;
        if ({px[0], py[0], r[0], g[0], b[0]} !== {7'd50, 6'd1, 24'h320133}) begin errors++; $display("FAIL gradient_y1 got x=%0d y=%0d rgb=%h exp x=50 y=1 rgb=320133", px[0], py[0], {r[0], g[0], b[0]}); end
    endtask

    task test_hblank;
        int lo = 0, na = 0, lsn = 0, bad = 0, hi4 = 0;
        repeat (2 * HT) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL hblank_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
            if (hs[0] === 1'b0) lo++;
            if (act[0] === 1'b1) na++;
            if (ls[0] === 1'b1) lsn++;
            if (act[0] !== 1'b1 && (px[0] !== 0 || {r[0], g[0], b[0]} !== 0)) bad++;
        end
        checks++;
        if (lo != 2 * HS) begin errors++; $display("FAIL hsync_width got=%0d exp=%0d", lo, 2 * HS); end
        checks++;
        if (na != 2 * HR) begin errors++; $display("FAIL active_width got=%0d exp=%0d", na, 2 * HR); end
        checks++;
        if (lsn != 2) begin errors++; $display("FAIL line_starts got=%0d exp=2", lsn); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL blank_zero got=%0d exp=0", bad); end
        repeat (8 * HT) begin
            @(negedge clk);
            if (hs[1] === 1'b1) hi4++;
        end
        checks++;
        if (hi4 != 4 * 2 * HS) begin errors++; $display("FAIL hsync_pos_pol got=%0d exp=%0d", hi4, 8 * HS); end
    endtask

    task test_frame;
        int vlo = 0, fsn = 0, lsn = 0, first = -1, per = 0;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL frame_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
            if (vs[0] === 1'b0) vlo++;
            if (ls[0] === 1'b1) lsn++;
            if (fs[0] === 1'b1) begin fsn++; if (first < 0) first = i; else per = i - first; end
        end
        checks++;
        if (vlo != 2 * VS * HT) begin errors++; $display("FAIL vsync_width got=%0d exp=%0d", vlo, 2 * VS * HT); end
        checks++;
        if (fsn != 2 || per != FL) begin errors++; $display("FAIL frame_period got count=%0d period=%0d exp count=2 period=%0d", fsn, per, FL); end
        checks++;
        if (lsn != 2 * VR) begin errors++; $display("FAIL lines_per_frame got=%0d exp=%0d", lsn, 2 * VR); end
    endtask

    task test_mode_switch;
        logic [23:0] want [6];
        int wx [6], wy [6];
        want = '{24'hFFFFFF, 24'hFFFF00, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        wx = '{0, 8, 63, 0, 8, 8};
        wy = '{0, 0, 0, 0, 0, 8};
        for (int s = 0; s < 6; s++) begin
            int i = 0;
            if (s == 0 || s == 3) begin
                if (s == 0) begin
                    for (i = 0; i < FL + 1 && fs[0] !== 1'b1; i++) @(negedge clk);
                    repeat (10 * HT) begin
                        @(negedge clk);
                        for (int d = 0; d < 2; d++) begin
                            checks++;
                            if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL mode_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
                        end
                    end
                end
                mode = s == 0 ? 2'd2 : 2'd3;
                @(negedge clk);
                for (i = 0; i < FL + 1 && fs[0] !== 1'b1; i++) begin
                    @(negedge clk);
                    for (int d = 0; d < 2; d++) begin
                        checks++;
                        if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL mode_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
                    end
                end
                checks++;
                if (fs[0] !== 1'b1) begin errors++; $display("FAIL mode_wait_frame got timeout exp frame_start"); end
            end else begin
                repeat ((wy[s] - wy[s - 1]) * HT + wx[s] - wx[s - 1]) begin
                    @(negedge clk);
                    for (int d = 0; d < 2; d++) begin
                        checks++;
                        if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL mode_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
                    end
                end
            end
            checks++;
            if ({px[0], py[0], r[0], g[0], b[0]} !== {7'(wx[s]), 6'(wy[s]), want[s]})
                begin errors++; $display("FAIL pattern_step%0d got x=%0d y=%0d rgb=%h exp x=%0d y=%0d rgb=%h", s, px[0], py[0], {r[0], g[0], b[0]}, wx[s], wy[s], want[s]); end
        end
    endtask

    task test_clkdiv_en;
        int pvn = 0, strb = 0;
        for (int i = 0; i < 8 && pv[1] !== 1'b1; i++) @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL div_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
            if (pv[1] === 1'b1) pvn++;
        end
        checks++;
        if (pvn != 4) begin errors++; $display("FAIL pix_valid_rate got=%0d exp=4", pvn); end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL freeze_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
                if (pv[d] !== 1'b0 || ls[d] !== 1'b0 || fs[d] !== 1'b0) strb++;
            end
        end
        checks++;
        if (strb != 0) begin errors++; $display("FAIL freeze_strobes got=%0d exp=0", strb); end
        en = 1'b1;
        repeat (21) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL resume_model dut%0d got=%h exp=%h", d, dut_vec(d), e[d]); end
            end
        end
        rst = 1'b1; mode = 2'd0;
        @(negedge clk);
        checks++;
        if ({hs[0], vs[0], hs[1], vs[1], pv[0], pv[1], act[0], act[1], px[0], px[1], r[1], g[0]} !== {4'b1100, 34'd0})
            begin errors++; $display("FAIL rst_mid got sync=%b%b%b%b act=%b%b x=%0d/%0d exp sync=1100 act=00 x=0/0", hs[0], vs[0], hs[1], vs[1], act[0], act[1], px[0], px[1]); end
        rst = 1'b0;
    endtask

    task test_random;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (dut_vec(d) !== e[d]) begin errors++; $display("FAIL random_model cyc%0d dut%0d got=%h exp=%h", i, d, dut_vec(d), e[d]); end
            end
            solid = 24'($urandom);
            en = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 499) == 0) mode = 2'($urandom);
            rst = $urandom_range(0, 1999) == 0;
        end
    endtask

    initial begin
        test_reset;
        test_gradient;
        test_hblank;
        test_frame;
        test_mode_switch;
        test_clkdiv_en;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
